// File: rtl/dilate_if.sv
// Pixel-stream bundle for the mask dilation stage: VTC counters, input mask
// pixel and dilated output pixel.
interface dilate_if;
    logic [11:0] VtcHCnt;
    logic [10:0] VtcVCnt;
    logic        render_i;
    logic        render_o;

    modport master (output VtcHCnt, VtcVCnt, render_i, input render_o);
    modport slave  (input VtcHCnt, VtcVCnt, render_i, output render_o);
endinterface

// File: rtl/dilate.sv
// 3x3 binary dilation of a VTC-timed mask stream. Two line buffers plus a
// column shift window; output is centred one pixel and one line behind.
module dilate #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240
) (
    input logic     PCLK,
    input logic     RST_N,
    dilate_if.slave vtc
);
    localparam int          AW     = $clog2(H_ACTIVE);
    localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);

    logic          act;
    logic [AW-1:0] hidx;
    logic          p1, p2, m1, m2, mh1, mh2, mv1, w;
    logic [2:0]    col0;
    logic [2:0]    col1_q, col1_d, col2_q, col2_d;
    logic [1:0]    rows_valid_q, rows_valid_d;
    logic          render_o_q, render_o_d;
    logic          lb1_q [H_ACTIVE];
    logic          lb2_q [H_ACTIVE];

    always_comb begin
        act  = (vtc.VtcHCnt < H_LIM) && (vtc.VtcVCnt < V_LIM);
        hidx = vtc.VtcHCnt[AW-1:0];
        p1   = lb1_q[hidx];
        p2   = lb2_q[hidx];
        mv1  = vtc.VtcVCnt >= 11'd1;
        // Rows only count once fully written since the last frame start/reset
        m1   = mv1 && (rows_valid_q >= 2'd1);
        m2   = (vtc.VtcVCnt >= 11'd2) && (rows_valid_q >= 2'd2);
        mh1  = vtc.VtcHCnt >= 12'd1;
        mh2  = vtc.VtcHCnt >= 12'd2;
        col0 = {p2 & m2, p1 & m1, vtc.render_i};
        w    = (|col0) | (|(col1_q & {3{mh1}})) | (|(col2_q & {3{mh2}}));

        col1_d       = col1_q;
        col2_d       = col2_q;
        rows_valid_d = rows_valid_q;
        if (act) begin
            col2_d = col1_q;
            col1_d = col0;
            if (vtc.VtcHCnt == 12'd0 && vtc.VtcVCnt == 11'd0)
                rows_valid_d = 2'd0;
            else if (vtc.VtcHCnt == H_LAST && rows_valid_q != 2'd2)
                rows_valid_d = rows_valid_q + 2'd1;
        end

        render_o_d = (act && mh1 && mv1) ? w : 1'b0;
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            col1_q       <= '0;
            col2_q       <= '0;
            rows_valid_q <= '0;
            render_o_q   <= 1'b0;
        end else begin
            col1_q       <= col1_d;
            col2_q       <= col2_d;
            rows_valid_q <= rows_valid_d;
            render_o_q   <= render_o_d;
        end
    end

    // Line buffers are unreset storage; stale content is masked by rows_valid
    always_ff @(posedge PCLK) begin
        if (act) begin
            lb2_q[hidx] <= lb1_q[hidx];
            lb1_q[hidx] <= vtc.render_i;
        end
    end

    assign vtc.render_o = render_o_q;
endmodule

// File: tb/tb_dilate.sv
// Scoreboard bench for dilate on a reduced 24x16 frame: stimulus pushes the
// hand-derived expected output per cycle, a monitor pops and compares.
module tb_dilate;
    localparam int H = 24, V = 16, H_TOT = 28, V_TOT = 19;
    localparam int T_RST = 0, T_ZERO = 1, T_PIX = 2, T_CORNER = 3, T_FULL = 4,
                   T_WRAPA = 5, T_WRAPB = 6, T_RMID_FULL = 7, T_RMID_ROW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, failures = 0;
    bit   exp_q[$];
    int   tag_q[$];

    dilate_if vif();
    dilate #(.H_ACTIVE(H), .V_ACTIVE(V)) u_dut (.PCLK(clk), .RST_N(rst_n), .vtc(vif));

    always #5 clk = ~clk;

    function automatic bit din_of(int t, int h, int v);
        case (t)
            T_RST, T_FULL, T_RMID_FULL: return 1'b1;
            T_PIX:      return (h == 10 && v == 6);
            T_CORNER:   return (h == 0 && v == 0);
            T_WRAPA:    return (v == V - 1 && h < H);
            T_RMID_ROW: return (v == 7 && h < H);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit exp_of(int t, int h, int v, bit in_rst);
        bit base;
        base = (h < H) && (v < V) && h >= 1 && v >= 1;
        if (in_rst) return 1'b0;
        case (t)
            T_PIX:       return (h >= 10 && h <= 12 && v >= 6 && v <= 8);
            T_CORNER:    return (h >= 1 && h <= 2 && v >= 1 && v <= 2);
            T_FULL, T_RMID_FULL: return base;
            T_WRAPA:     return base && v == V - 1;
            T_RMID_ROW:  return base && (v == 7 || (v == 8 && h <= 9));
            default:     return 1'b0;
        endcase
    endfunction

    task automatic drive(int t, int h, int v, bit rstn);
        @(negedge clk);
        rst_n        = rstn;
        vif.VtcHCnt  = 12'(h);
        vif.VtcVCnt  = 11'(v);
        vif.render_i = din_of(t, h, v);
        exp_q.push_back(exp_of(t, h, v, !rstn));
        tag_q.push_back(t * 100000 + v * 100 + h);
    endtask

    // rv < 0 disables the mid-frame reset pulse
    task automatic run_frame(int t, int rv, int rh);
        for (int v = 0; v < V_TOT; v++)
            for (int h = 0; h < H_TOT; h++)
                drive(t, h, v, !(v == rv && h >= rh && h < rh + 3));
    endtask

    initial begin : monitor
        bit e;
        int tag;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                tag = tag_q.pop_front();
                checks++;
                if (vif.render_o !== e) begin
                    failures++;
                    $display("FAIL render_o test=%0d v=%0d h=%0d got=%b want=%b",
                             tag / 100000, (tag % 100000) / 100, tag % 100, vif.render_o, e);
                end
            end
        end
    end

    initial begin : stim
        vif.VtcHCnt  = 12'd5;
        vif.VtcVCnt  = 11'd5;
        vif.render_i = 1'b1;
        repeat (50) drive(T_RST, 5, 5, 1'b0);
        run_frame(T_ZERO, -1, 0);
        run_frame(T_PIX, -1, 0);
        run_frame(T_CORNER, -1, 0);
        run_frame(T_FULL, -1, 0);
        run_frame(T_WRAPA, -1, 0);
        run_frame(T_WRAPB, -1, 0);
        run_frame(T_RMID_FULL, 8, 10);
        run_frame(T_RMID_ROW, 8, 10);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
